multi_dataflow_engine: RTL

- Engine-side responder to the multi_dataflow controller FSM.
- Consumes ctrl_engine_t commands (clear, enable, start, cnt_limit_outStream0, reg_simple_mul, reg_shift, reg_len) and returns flags_engine_t (ready, cnt_outStream0).
- Joins the three HWPE input streams inStream0..2, computes one result per element in a 2-stage pipeline, and drives outStream0.
- Sits between the streamer (source/sink FIFOs) and the controller inside the multi_dataflow HWPE top.

---
 rtl/multi_dataflow_engine_pkg.sv | 39 +++
 rtl/multi_dataflow_engine_datapath.sv | 113 +++++++++++
 rtl/multi_dataflow_engine.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multi_dataflow_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_package
// Description : Shared widths, controller/engine interface structs and the
//               engine state encoding for the multi_dataflow engine.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_dataflow_package;

  localparam int ENG_DATA_W  = 32;
  localparam int ENG_CNT_W   = 16;
  localparam int ENG_SHIFT_W = 5;

  // Engine job state
  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_t;

  // Controller -> engine command bundle
  typedef struct packed {
    logic                   clear;
    logic                   enable;
    logic                   start;
    logic [ENG_CNT_W-1:0]   cnt_limit_out_stream0;
    logic [ENG_DATA_W-1:0]  reg_simple_mul;
    logic [ENG_SHIFT_W-1:0] reg_shift;
    logic [ENG_CNT_W-1:0]   reg_len;
  } ctrl_engine_t;

  // Engine -> controller status bundle
  typedef struct packed {
    logic                 ready;
    logic [ENG_CNT_W-1:0] cnt_out_stream0;
  } flags_engine_t;

endpackage
`default_nettype wire

// File: rtl/multi_dataflow_engine_datapath.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_engine_datapath
// Description : Two-stage pipeline: stage 1 multiplies in0 by the job
//               multiplier and sign-extends in1/in2; stage 2 adds, shifts
//               arithmetically and narrows to DATA_W. Valid/ready control.
//               Optional: MULTI_DATAFLOW_ENGINE_SAT_EN saturates the result
//               to the signed DATA_W range instead of truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_engine_datapath
  import multi_dataflow_package::*;
#(
  parameter int DATA_W = ENG_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   in_fire_i,
  input  logic [DATA_W-1:0]      in0_data_i,
  input  logic [DATA_W-1:0]      in1_data_i,
  input  logic [DATA_W-1:0]      in2_data_i,
  input  logic [DATA_W-1:0]      mul_i,
  input  logic [ENG_SHIFT_W-1:0] shift_i,
  output logic                   s1_accept_o,
  output logic                   busy_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  localparam int WIDE_W = 2 * DATA_W;

  logic                     s1_valid;
  logic signed [WIDE_W-1:0] s1_prod;
  logic signed [WIDE_W-1:0] s1_add1;
  logic signed [WIDE_W-1:0] s1_add2;
  logic signed [WIDE_W-1:0] in0_wide;
  logic signed [WIDE_W-1:0] mul_wide;
  logic signed [WIDE_W-1:0] sum;
  logic signed [WIDE_W-1:0] shifted;
  logic [DATA_W-1:0]        result;
  logic                     s2_advance;

  assign s2_advance  = enable_i & (~out_valid_o | out_ready_i);
  assign s1_accept_o = ~s1_valid | s2_advance;
  assign busy_o      = s1_valid | out_valid_o;

  assign in0_wide = WIDE_W'($signed(in0_data_i));
  assign mul_wide = WIDE_W'($signed(mul_i));
  assign sum      = s1_prod + s1_add1 + s1_add2;
  assign shifted  = sum >>> shift_i;

`ifdef MULTI_DATAFLOW_ENGINE_SAT_EN
  localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp the shifted sum into the signed DATA_W range
  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  logic unused_high;
  assign unused_high = ^shifted[WIDE_W-1:DATA_W];
  assign result      = shifted[DATA_W-1:0];
`endif

  // Stage 1: capture product and sign-extended addends on an input fire
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_add1  <= '0;
      s1_add2  <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_add1  <= '0;
      s1_add2  <= '0;
    end else if (enable_i && s1_accept_o) begin
      s1_valid <= in_fire_i;
      if (in_fire_i) begin
        s1_prod <= in0_wide * mul_wide;
        s1_add1 <= WIDE_W'($signed(in1_data_i));
        s1_add2 <= WIDE_W'($signed(in2_data_i));
      end
    end
  end

  // Stage 2: output register, held while the sink stalls or enable is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (s2_advance) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        out_data_o <= result;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_dataflow_engine.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_engine
// Description : Engine responder for the multi_dataflow controller. Joins
//               three input streams, runs the mul/add/shift pipeline and
//               tracks per-job input/output counts and job state.
//               Optional: MULTI_DATAFLOW_ENGINE_SAT_EN enables output
//               saturation in the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_engine
  import multi_dataflow_package::*;
#(
  parameter int DATA_W = ENG_DATA_W,
  parameter int CNT_W  = ENG_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       cnt_limit_i,
  input  logic [DATA_W-1:0]      reg_simple_mul_i,
  input  logic [ENG_SHIFT_W-1:0] reg_shift_i,
  input  logic [CNT_W-1:0]       reg_len_i,
  input  logic [DATA_W-1:0]      in0_data_i,
  input  logic [DATA_W-1:0]      in1_data_i,
  input  logic [DATA_W-1:0]      in2_data_i,
  input  logic                   in0_valid_i,
  input  logic                   in1_valid_i,
  input  logic                   in2_valid_i,
  output logic                   in0_ready_o,
  output logic                   in1_ready_o,
  output logic                   in2_ready_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   ready_o,
  output logic [CNT_W-1:0]       cnt_out_o
);

  eng_state_t             state;
  eng_state_t             state_next;
  logic [CNT_W-1:0]       in_cnt;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       limit_q;
  logic [DATA_W-1:0]      mul_q;
  logic [ENG_SHIFT_W-1:0] shift_q;
  logic                   start_job;
  logic                   fire;
  logic                   s1_accept;
  logic                   busy;
  logic                   out_hs;

  // A start pulse is honoured only outside RUN
  assign start_job = start_i & (state != ENG_RUN);
  assign fire      = (state == ENG_RUN) & enable_i & in0_valid_i & in1_valid_i
                   & in2_valid_i & (in_cnt < len_q) & s1_accept;
  assign out_hs    = out_valid_o & out_ready_i & enable_i;

  assign in0_ready_o = fire;
  assign in1_ready_o = fire;
  assign in2_ready_o = fire;

  // Job state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ENG_IDLE;
    end else if (clear_i) begin
      state <= ENG_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and ready flag; RUN ends once the limit is met with nothing in flight
  always_comb begin
    state_next = state;
    ready_o    = 1'b1;
    case (state)
      ENG_IDLE, ENG_DONE: begin
        if (start_i) begin
          state_next = (reg_len_i == '0) ? ENG_DONE : ENG_RUN;
        end
      end
      ENG_RUN: begin
        ready_o = 1'b0;
        if ((cnt_out_o == limit_q) && !busy) begin
          state_next = ENG_DONE;
        end
      end
      default: state_next = ENG_IDLE;
    endcase
  end

  // Job configuration latched on an accepted start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      limit_q <= '0;
    end else if (clear_i) begin
      mul_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      limit_q <= '0;
    end else if (start_job) begin
      mul_q   <= reg_simple_mul_i;
      shift_q <= reg_shift_i;
      len_q   <= reg_len_i;
      limit_q <= cnt_limit_i;
    end
  end

  // Input and output element counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_cnt    <= '0;
      cnt_out_o <= '0;
    end else if (clear_i || start_job) begin
      in_cnt    <= '0;
      cnt_out_o <= '0;
    end else begin
      if (fire) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (out_hs) begin
        cnt_out_o <= cnt_out_o + 1'b1;
      end
    end
  end

  multi_dataflow_engine_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .in_fire_i   (fire),
    .in0_data_i  (in0_data_i),
    .in1_data_i  (in1_data_i),
    .in2_data_i  (in2_data_i),
    .mul_i       (mul_q),
    .shift_i     (shift_q),
    .s1_accept_o (s1_accept),
    .busy_o      (busy),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

endmodule
`default_nettype wire
